clk_buf_pipe: RTL and testbench
===============================

CLK_BUF_PIPE -- requirements
Module: clk_buf_pipe

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits, legal range 1..64.
REQ-002 Parameter DEPTH, default 4: number of register stages, legal range 1..16.
REQ-003 Parameter RESET_VAL, default 0: WIDTH-bit value loaded into every data stage on reset.
REQ-004 clk  input  1  pad clock; SHALL pass through one CLK_BUF instance, and the CLK_BUF output SHALL clock every flop.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 enable  input  1  global advance qualifier; 0 freezes all state.
REQ-007 flush  input  1  synchronous clear of all stage valid bits.
REQ-008 in_valid  input  1  data_i holds a word to accept.
REQ-009 in_ready  output  1  block accepts data_i at this edge.
REQ-010 data_i  input  WIDTH  input word.
REQ-011 out_valid  output  1  data_o holds a valid word.
REQ-012 out_ready  input  1  consumer takes data_o at this edge.
REQ-013 data_o  output  WIDTH  last-stage word.
REQ-014 count  output  $clog2(DEPTH+1)  number of occupied stages.

Function
REQ-015 The block SHALL hold stages 0..DEPTH-1, each with a data register and a valid bit; stage 0 is the input side and stage DEPTH-1 drives data_o/out_valid directly from flops.
REQ-016 An accept SHALL occur at an edge where in_valid=1 and in_ready=1; a drain SHALL occur at an edge where out_valid=1, out_ready=1 and enable=1.
REQ-017 Stage k<DEPTH-1 SHALL advance into stage k+1 when stage k is valid and stage k+1 is empty or advancing (drains, for k+1=DEPTH-1).
REQ-018 Bubbles SHALL collapse: a valid word SHALL never wait behind an empty downstream stage.
REQ-019 in_ready SHALL equal enable & ~flush & (stage 0 empty | stage 0 advancing); the ready path is combinational.
REQ-020 Latency: into an empty pipe with out_ready=1 and enable=1, a word accepted at edge t SHALL present out_valid=1 with that word after edge t+DEPTH-1.
REQ-021 Throughput: with enable=1, in_valid=1 and out_ready=1 continuously, the block SHALL accept and drain one word per cycle.
REQ-022 Words SHALL leave in acceptance order, with no loss and no duplication.
REQ-023 enable=0 SHALL hold every data register, valid bit and count; in_ready=0; no drain occurs, and out_valid/data_o hold their values.
REQ-024 flush=1 with enable=1 SHALL clear all valid bits and set count to 0 at the edge, with priority over accept, advance and drain; data registers are unchanged.
REQ-025 flush=1 with enable=0 SHALL have no effect.
REQ-026 Full (count=DEPTH) with out_ready=0 SHALL force in_ready=0.
REQ-027 Accept and drain at the same edge SHALL leave count unchanged; accept only adds 1; drain only subtracts 1.
REQ-028 count SHALL always equal the number of set valid bits, and SHALL never exceed DEPTH or wrap below 0.
REQ-029 DEPTH=1 SHALL give a single-register elastic stage: in_ready = enable & ~flush & (~out_valid | out_ready).

Reset
REQ-030 rst_n=0 SHALL asynchronously clear all valid bits, set count=0 and out_valid=0, and load RESET_VAL into every data stage, so data_o=RESET_VAL.
REQ-031 Reset asserted mid-transfer SHALL discard all in-flight words; no word accepted before reset appears after it.
REQ-032 The first accept SHALL be possible at the first buffered-clock edge after rst_n deasserts.

Verification
REQ-033 WIDTH=8, DEPTH=4, empty pipe; accept 0xA5 at edge 0 with out_ready=1 -> out_valid=1 and data_o=0xA5 after edge 3, count=1.
REQ-034 out_ready=0, in_valid=1 with 0x01..0x05 -> 0x01..0x04 accepted, count=4, in_ready=0; then out_ready=1 -> 0x01..0x05 emerge in order, one per cycle.
REQ-035 Streaming 0x10..0x1F with in_valid=out_ready=1 -> 16 accepts in 16 cycles, count constant at DEPTH once primed, no gaps.
REQ-036 Pipe holding 3 words, enable=0 for 5 cycles while out_ready=1 -> count=3, data_o constant, in_ready=0; then enable=1 -> draining resumes in order.
REQ-037 count=3 with flush=1 and in_valid=1 at the same edge -> count=0, out_valid=0, no accept; flush=1 with enable=0 -> count unchanged.
REQ-038 RESET_VAL=0x3C, pipe full, rst_n pulsed low between clock edges -> out_valid=0, count=0 and data_o=0x3C immediately, without waiting for an edge.

Source files
------------

// File: rtl/clk_buf_pipe.sv
// Elastic register pipeline whose flops are all clocked from one buffered copy
// of the pad clock. Bubbles collapse, the ready path is combinational and
// enable/flush qualify every state change.

// Clock buffer cell: the single point where the pad clock enters the block.
module CLK_BUF (
    input  logic I,
    output logic O
);
    assign O = I;
endmodule

module clk_buf_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           data_i,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH+1);

    logic             clk_i_buf;
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] mv;       // stage k hands its word downstream (last stage: drains)
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic             acc;
    logic             drn;

    CLK_BUF u_clk_buf (.I(clk), .O(clk_i_buf));

    // Advance chain resolved from the output side back to the input, so a
    // draining tail lets the whole pipe shift in the same cycle.
    always_comb begin
        mv = '0;
        mv[DEPTH-1] = enable & vld_q[DEPTH-1] & out_ready;
        for (int k = DEPTH-2; k >= 0; k--)
            mv[k] = enable & vld_q[k] & (~vld_q[k+1] | mv[k+1]);
        drn      = mv[DEPTH-1];
        in_ready = enable & ~flush & (~vld_q[0] | mv[0]);
        acc      = in_valid & in_ready;
    end

    // Stage state and occupancy; flush wins over every move, data is left alone.
    always_ff @(posedge clk_i_buf or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++)
                data_q[k] <= RESET_VAL;
        end else if (enable) begin
            if (flush) begin
                vld_q   <= '0;
                count_q <= '0;
            end else begin
                vld_q[0] <= (vld_q[0] & ~mv[0]) | acc;
                if (acc)
                    data_q[0] <= data_i;
                for (int k = 1; k < DEPTH; k++) begin
                    vld_q[k] <= (vld_q[k] & ~mv[k]) | mv[k-1];
                    if (mv[k-1])
                        data_q[k] <= data_q[k-1];
                end
                count_q <= count_q + CW'(acc) - CW'(drn);
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign data_o    = data_q[DEPTH-1];
    assign count     = count_q;

endmodule

// File: tb/tb_clk_buf_pipe.sv
// Directed bench for clk_buf_pipe (WIDTH=8, DEPTH=4, RESET_VAL=0x3C).
// Accepted words go into a queue; a negedge monitor pops and compares drains.
module tb_clk_buf_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] data_i = '0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] data_o;
    logic [2:0] count;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         start;
    logic [7:0] exp_q [$];

    clk_buf_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h3C)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .data_i(data_i),
        .out_valid(out_valid), .out_ready(out_ready), .data_o(data_o),
        .count(count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: occupancy tracks in-flight words, drains come out in order.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count_vs_inflight", count, exp_q.size());
            if (enable && flush)
                exp_q.delete();
            else if (enable && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word: got %0h expected none", data_o);
                end else
                    chk("data_order", data_o, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] v);
        data_i   = v;
        in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                exp_q.push_back(v);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL send_timeout: word %0h not accepted", v);
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (count == 0) begin
                @(posedge clk); #1;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL drain_timeout: count %0d expected 0", count);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_data", data_o, 8'h3C);
        rst_n = 1'b1;

        // latency: first accept right after reset, visible after edge t+3
        send(8'hA5);
        chk("lat_count_e0", count, 3'd1);
        chk("lat_ov_e0", out_valid, 1'b0);
        step(); step();
        chk("lat_ov_e2", out_valid, 1'b0);
        step();
        chk("lat_ov_e3", out_valid, 1'b1);
        chk("lat_data_e3", data_o, 8'hA5);
        chk("lat_count_e3", count, 3'd1);
        wait_empty();

        // backpressure: fill to DEPTH, then release
        out_ready = 1'b0;
        for (int v = 1; v <= 4; v++) send(8'(v));
        data_i = 8'h05; in_valid = 1'b1;
        @(negedge clk);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_count", count, 3'd4);
        chk("full_head", data_o, 8'h01);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(8'h05);
        chk("release_count", count, 3'd4);
        start = cyc;
        wait_empty();
        chk("drain_cycles", cyc - start, 5);

        // streaming throughput
        start = cyc;
        for (int i = 0; i < 16; i++) begin
            send(8'h10 + 8'(i));
            chk("stream_count", count, (i < 3) ? 3'(i + 1) : 3'd4);
        end
        chk("stream_cycles", cyc - start, 16);
        wait_empty();

        // enable=0 freezes a 3-word pipe
        out_ready = 1'b0;
        send(8'h21); send(8'h22); send(8'h23);
        step(); step();
        enable = 1'b0; out_ready = 1'b1; in_valid = 1'b1; data_i = 8'h99;
        repeat (5) begin
            @(negedge clk);
            chk("frz_count", count, 3'd3);
            chk("frz_data", data_o, 8'h21);
            chk("frz_in_ready", in_ready, 1'b0);
            chk("frz_out_valid", out_valid, 1'b1);
        end
        @(posedge clk); #1;
        enable = 1'b1; in_valid = 1'b0;
        wait_empty();

        // flush: ignored while disabled, dominant when enabled
        out_ready = 1'b0;
        send(8'h31); send(8'h32); send(8'h33);
        step();
        enable = 1'b0; flush = 1'b1;
        step();
        chk("flush_dis_count", count, 3'd3);
        enable = 1'b1; in_valid = 1'b1; data_i = 8'h44;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", count, 3'd0);
        chk("flush_out_valid", out_valid, 1'b0);
        out_ready = 1'b1;

        // asynchronous reset of a full pipe between edges
        out_ready = 1'b0;
        send(8'h51); send(8'h52); send(8'h53); send(8'h54);
        chk("pre_rst_count", count, 3'd4);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_count", count, 3'd0);
        chk("arst_data", data_o, 8'h3C);
        exp_q.delete();
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        send(8'h61);
        wait_empty();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
